fm_lane_downconv: RTL and testbench

//  Wide-to-narrow stream converter feeding the conv array: accepts IN_W-bit feature-map words (AXIS side),

---
 rtl/conv_acc_pkg.sv | 24 ++
 rtl/fm_lane_downconv_chk.sv | 17 +
 rtl/fm_word_fifo.sv | 65 ++++++
 rtl/fm_lane_downconv.sv | 147 ++++++++++++++
 tb/tb_fm_lane_downconv.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/conv_acc_pkg.sv
// Shared definitions for the conv-array feature-map path: default word/lane
// widths, the lane-count width helper and the buffered word layout.
package conv_acc_pkg;

    localparam int FM_IN_W  = 512;
    localparam int FM_OUT_W = 64;

    // Width of a lane-count field able to hold 0..lanes inclusive.
    function automatic int fm_lane_cnt_w(input int lanes);
        return $clog2(lanes) + 1;
    endfunction

    localparam int FM_LANES = FM_IN_W / FM_OUT_W;
    localparam int FM_LW    = fm_lane_cnt_w(FM_LANES);

    // Buffered word layout at the default widths; the converter packs its
    // FIFO entries in this same {data, lanes, last} order.
    typedef struct packed {
        logic [FM_IN_W-1:0] data;
        logic [FM_LW-1:0]   lanes;
        logic               last;
    } fm_word_t;

endpackage

// File: rtl/fm_lane_downconv_chk.sv
// Simulation checks for the lane converter's input side: an accepted word
// must never advertise more lanes than a word physically carries.
module fm_lane_downconv_chk #(
    parameter int LANES = 8,
    parameter int LW    = 4
) (
    input logic          clk,
    input logic          rst,
    input logic          s_valid,
    input logic          s_ready,
    input logic [LW-1:0] s_lanes
);

    a_lanes_legal: assert property (@(posedge clk) disable iff (rst)
        (s_valid && s_ready) |-> (s_lanes <= LW'(LANES)));

endmodule

// File: rtl/fm_word_fifo.sv
// DEPTH-entry synchronous FIFO holding packed {data, lanes, last} words.
// Read side is first-word-fall-through: rdata always shows the head entry.
// Pointers wrap naturally (DEPTH is a power of two); count is kept separately.
module fm_word_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 2,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] count_q;

    // Storage array: cleared on reset so the head never carries stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_q] <= wdata;
        end else begin
            mem_q[wr_q] <= mem_q[wr_q];
        end
    end

    // Read/write pointers and occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + AW'(1);
            end else begin
                wr_q <= wr_q;
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end else begin
                rd_q <= rd_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_q];
    assign count = count_q;

endmodule

// File: rtl/fm_lane_downconv.sv
// Wide-to-narrow feature-map converter: buffers IN_W-bit words and emits them
// as OUT_W-bit lanes, one per accepted handshake, honouring partial last words.
// Build option FM_LANE_MSB_FIRST_EN: lanes leave from the MSB end of each word
// (and partial words occupy the MSB end); default is LSB-first.
module fm_lane_downconv
    import conv_acc_pkg::*;
#(
    parameter  int IN_W  = FM_IN_W,
    parameter  int OUT_W = FM_OUT_W,
    parameter  int DEPTH = 2,
    localparam int LANES = IN_W / OUT_W,
    localparam int LW    = fm_lane_cnt_w(LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [IN_W-1:0]  s_data,
    input  logic [LW-1:0]    s_lanes,
    input  logic             s_last,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [OUT_W-1:0] m_data,
    output logic             m_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [LW-1:0]    occupancy
);

    localparam int EW = IN_W + LW + 1;
    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic             clr_s;
    logic [LW-1:0]    lanes_eff_s;
    logic [EW-1:0]    wentry_s;
    logic [EW-1:0]    head_s;
    logic [IN_W-1:0]  head_data_s;
    logic [LW-1:0]    head_lanes_s;
    logic             head_last_s;
    logic [CW-1:0]    count_s;
    logic             push_s;
    logic             take_s;
    logic             last_lane_s;
    logic             retire_s;
    logic [PW-1:0]    lane_idx_s;
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_d;
    logic             armed_q;

    // Abort and reset both wipe the buffer; reset simply wins when both are set.
    assign clr_s = rst | flush;

    // Normalise the lane count: 0 means a full word, oversize counts clamp.
    always_comb begin
        if ((s_lanes == '0) || (s_lanes > LW'(LANES))) begin
            lanes_eff_s = LW'(LANES);
        end else begin
            lanes_eff_s = s_lanes;
        end
    end

    assign wentry_s     = {s_data, lanes_eff_s, s_last};
    assign head_data_s  = head_s[EW-1 -: IN_W];
    assign head_lanes_s = head_s[1 +: LW];
    assign head_last_s  = head_s[0];

    // Acceptance is decided from registered state only: a word retiring this
    // cycle does not open a slot until the next cycle.
    assign s_ready   = armed_q & (count_s < CW'(DEPTH));
    assign m_valid   = (count_s != '0);
    assign occupancy = LW'(count_s);

    assign push_s      = s_valid & s_ready;
    assign take_s      = m_valid & m_ready;
    assign last_lane_s = (LW'(ptr_q) == (head_lanes_s - LW'(1)));
    assign retire_s    = take_s & last_lane_s;

    fm_word_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (clr_s),
        .push  (push_s),
        .pop   (retire_s),
        .wdata (wentry_s),
        .rdata (head_s),
        .count (count_s)
    );

    // Next lane pointer: advance per taken lane, wrap to 0 when the word retires.
    always_comb begin
        ptr_d = ptr_q;
        if (take_s) begin
            if (last_lane_s) begin
                ptr_d = '0;
            end else begin
                ptr_d = ptr_q + PW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Lane pointer and the one-cycle post-clear input hold-off.
    always_ff @(posedge clk) begin
        if (clr_s) begin
            ptr_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            armed_q <= 1'b1;
        end
    end

    // Map the lane pointer onto a physical lane slot of the head word.
    always_comb begin
`ifdef FM_LANE_MSB_FIRST_EN
        lane_idx_s = PW'(LANES - 1) - ptr_q;
`else
        lane_idx_s = ptr_q;
`endif
    end

    // Lane mux; an empty buffer presents zero data and no end marker.
    always_comb begin
        if (m_valid) begin
            m_data = head_data_s[lane_idx_s * OUT_W +: OUT_W];
            m_last = head_last_s & last_lane_s;
        end else begin
            m_data = '0;
            m_last = 1'b0;
        end
    end

    fm_lane_downconv_chk #(
        .LANES (LANES),
        .LW    (LW)
    ) u_chk (
        .clk     (clk),
        .rst     (clr_s),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_lanes (s_lanes)
    );

endmodule

// File: tb/tb_fm_lane_downconv.sv
// Randomised self-checking bench for fm_lane_downconv. A word-level queue
// model predicts every lane, end marker, handshake and occupancy each cycle.
module tb_fm_lane_downconv;

    localparam int IN_W  = 512;
    localparam int OUT_W = 64;
    localparam int DEPTH = 2;
    localparam int LANES = IN_W / OUT_W;
    localparam int LW    = $clog2(LANES) + 1;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [IN_W-1:0]  s_data;
    logic [LW-1:0]    s_lanes;
    logic             s_last;
    logic             s_valid;
    logic             s_ready;
    logic [OUT_W-1:0] m_data;
    logic             m_last;
    logic             m_valid;
    logic             m_ready;
    logic [LW-1:0]    occupancy;

    fm_lane_downconv #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .s_data    (s_data),
        .s_lanes   (s_lanes),
        .s_last    (s_last),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .occupancy (occupancy)
    );

    typedef struct {
        logic [IN_W-1:0] data;
        int              k;
        bit              last;
    } word_t;

    word_t q[$];
    int    hidx;
    bit    armed;
    int    n_checks;
    int    n_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [IN_W-1:0] rnd_word();
        logic [IN_W-1:0] w;
        for (int i = 0; i < IN_W / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [IN_W-1:0] ramp_word();
        logic [IN_W-1:0] w;
        for (int i = 0; i < LANES; i++) w[i*OUT_W +: OUT_W] = 64'(i);
        return w;
    endfunction

    // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
    task automatic step(input bit sv, input logic [IN_W-1:0] d, input int ln, input bit lst,
                        input bit mr, input bit fl, input bit rs, output bit acc);
        bit              exp_valid;
        bit              exp_ready;
        bit              pop;
        int              li;
        logic [IN_W-1:0] hd;
        word_t           w;
        s_valid = sv;
        s_data  = d;
        s_lanes = LW'(ln);
        s_last  = lst;
        m_ready = mr;
        flush   = fl;
        rst     = rs;
        @(negedge clk);
        exp_valid = (q.size() != 0);
        exp_ready = armed && (q.size() < DEPTH);
        check_eq("m_valid", 64'(m_valid), 64'(exp_valid));
        check_eq("s_ready", 64'(s_ready), 64'(exp_ready));
        check_eq("occupancy", 64'(occupancy), 64'(q.size()));
        if (exp_valid) begin
            hd = q[0].data;
`ifdef FM_LANE_MSB_FIRST_EN
            li = LANES - 1 - hidx;
`else
            li = hidx;
`endif
            check_eq("m_data", m_data, hd[li*OUT_W +: OUT_W]);
            check_eq("m_last", 64'(m_last), 64'(q[0].last && (hidx == q[0].k - 1)));
        end else begin
            check_eq("m_data_empty", m_data, 64'd0);
            check_eq("m_last_empty", 64'(m_last), 64'd0);
        end
        acc = sv && exp_ready && !fl && !rs;
        pop = exp_valid && mr && !fl && !rs;
        @(posedge clk);
        if (rs || fl) begin
            q.delete();
            hidx  = 0;
            armed = 1'b0;
        end else begin
            armed = 1'b1;
            if (pop) begin
                hidx++;
                if (hidx == q[0].k) begin
                    void'(q.pop_front());
                    hidx = 0;
                end
            end
            if (acc) begin
                w.data = d;
                w.k    = ((ln == 0) || (ln > LANES)) ? LANES : ln;
                w.last = lst;
                q.push_back(w);
            end
        end
        #1;
    endtask

    // Present one word until accepted; m_ready fixed or randomised per cycle.
    task automatic send(input logic [IN_W-1:0] d, input int ln, input bit lst,
                        input bit mr_fixed, input bit mr_rand);
        bit acc;
        bit mr;
        acc = 1'b0;
        for (int t = 0; t < 200 && !acc; t++) begin
            mr = mr_rand ? 1'($urandom_range(0, 1)) : mr_fixed;
            step(1'b1, d, ln, lst, mr, 1'b0, 1'b0, acc);
        end
        check_eq("send_accepted", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n, input bit mr);
        bit acc;
        for (int t = 0; t < n; t++) step(1'b0, rnd_word(), 0, 1'b0, mr, 1'b0, 1'b0, acc);
    endtask

    initial begin
        bit acc;
        n_checks = 0;
        n_err    = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_lanes  = '0;
        s_last   = 1'b0;
        m_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        hidx  = 0;
        armed = 1'b0;

        // Reset state, then one full ramp word drained at full rate.
        idle(2, 1'b1);
        send(ramp_word(), 0, 1'b0, 1'b1, 1'b0);
        idle(10, 1'b1);

        // Four back-to-back words, end marker on the last lane of word 4.
        for (int i = 0; i < 4; i++) send(rnd_word(), LANES, (i == 3), 1'b1, 1'b0);
        idle(20, 1'b1);

        // Partial last word (3 lanes) followed immediately by a full word.
        send(ramp_word(), 3, 1'b1, 1'b1, 1'b0);
        send(rnd_word(), 0, 1'b0, 1'b1, 1'b0);
        idle(12, 1'b1);

        // Random stalls with the buffer kept full.
        send(rnd_word(), 0, 1'b0, 1'b0, 1'b0);
        send(rnd_word(), 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send(rnd_word(), $urandom_range(0, LANES), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        idle(60, 1'b1);

        // Abort mid-word with a full buffer: flush pass, then reset pass.
        for (int pass = 0; pass < 2; pass++) begin
            send(rnd_word(), 0, 1'b0, 1'b0, 1'b0);
            send(rnd_word(), 0, 1'b1, 1'b0, 1'b0);
            idle(5, 1'b1);
            step(1'b1, rnd_word(), 0, 1'b0, 1'b1, (pass == 0), (pass == 1), acc);
            idle(2, 1'b1);
            send(ramp_word(), 0, 1'b1, 1'b1, 1'b0);
            idle(10, 1'b1);
        end

        // Free-running random traffic with occasional aborts.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), rnd_word(), $urandom_range(0, LANES),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 99) == 0), ($urandom_range(0, 199) == 0), acc);
        end
        idle(30, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
